// File: rtl/powlib_cntr_flag_ff.sv
// Counter, set/clear flag and data flip-flop. Each of the three is independent,
// registered, and reset synchronously by an active-low rst.
module powlib_cntr_flag_ff #(
  parameter int unsigned CNTR_W    = 8,
  parameter int unsigned CNTR_INIT = 0,
  parameter bit          CNTR_ELD  = 1'b0,
  parameter bit          FLAG_INIT = 1'b1,
  parameter int unsigned FF_W      = 8,
  parameter int unsigned FF_INIT   = 0,
  parameter bit          FF_EVLD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cntr_adv,
  input  logic              cntr_clr,
  input  logic              cntr_ld,
  input  logic [CNTR_W-1:0] cntr_ldval,
  output logic [CNTR_W-1:0] cntr,
  input  logic              flag_set,
  input  logic              flag_clr,
  output logic              flag_q,
  input  logic [FF_W-1:0]   ff_d,
  input  logic              ff_vld,
  output logic [FF_W-1:0]   ff_q
);

  localparam logic [CNTR_W-1:0] CNTR_RST = CNTR_W'(CNTR_INIT);
  localparam logic [FF_W-1:0]   FF_RST   = FF_W'(FF_INIT);

  logic [CNTR_W-1:0] cntr_nxt;
  logic              flag_nxt;
  logic [FF_W-1:0]   ff_nxt;

  // Clear beats load beats advance; the increment wraps naturally at 2^CNTR_W.
  always_comb begin
    // NOTE: default first so every path assigns cntr_nxt and no latch is inferred.
    cntr_nxt = cntr;
    if (cntr_clr)
      cntr_nxt = CNTR_RST;
    else if (CNTR_ELD && cntr_ld)
      cntr_nxt = cntr_ldval;
    else if (cntr_adv)
      cntr_nxt = cntr + CNTR_W'(1);
  end

  // Set wins over clear when both are requested.
  always_comb begin
    flag_nxt = flag_q;
    if (flag_set)
      flag_nxt = 1'b1;
    else if (flag_clr)
      flag_nxt = 1'b0;
  end

  always_comb begin
    ff_nxt = ff_q;
    if (!FF_EVLD || ff_vld)
      ff_nxt = ff_d;
  end

  // NOTE: reset is tested inside the clocked block only (synchronous), and all
  // state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cntr   <= CNTR_RST;
      flag_q <= FLAG_INIT;
      ff_q   <= FF_RST;
    end else begin
      cntr   <= cntr_nxt;
      flag_q <= flag_nxt;
      ff_q   <= ff_nxt;
    end
  end

endmodule

// File: tb/tb_powlib_cntr_flag_ff.sv
// Bench for powlib_cntr_flag_ff: two configurations share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed literals.
module tb_powlib_cntr_flag_ff;

  logic       clk = 1'b0;
  logic       rst;
  logic       cntr_adv, cntr_clr, cntr_ld;
  logic [7:0] cntr_ldval;
  logic       flag_set, flag_clr;
  logic [7:0] ff_d;
  logic       ff_vld;

  logic [2:0] a_cntr;
  logic       a_flag;
  logic [7:0] a_ff;
  logic [7:0] b_cntr;
  logic       b_flag;
  logic [7:0] b_ff;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Config A: 3-bit counter with load enabled, enabled flip-flop, default inits.
  powlib_cntr_flag_ff #(
    .CNTR_W(3), .CNTR_INIT(0), .CNTR_ELD(1'b1), .FLAG_INIT(1'b1),
    .FF_W(8), .FF_INIT(0), .FF_EVLD(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .cntr_adv(cntr_adv), .cntr_clr(cntr_clr), .cntr_ld(cntr_ld),
    .cntr_ldval(cntr_ldval[2:0]), .cntr(a_cntr),
    .flag_set(flag_set), .flag_clr(flag_clr), .flag_q(a_flag),
    .ff_d(ff_d), .ff_vld(ff_vld), .ff_q(a_ff)
  );

  // Config B: 8-bit counter with load ignored, free-running flip-flop, non-zero inits.
  powlib_cntr_flag_ff #(
    .CNTR_W(8), .CNTR_INIT(3), .CNTR_ELD(1'b0), .FLAG_INIT(1'b0),
    .FF_W(8), .FF_INIT(8'h5A), .FF_EVLD(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .cntr_adv(cntr_adv), .cntr_clr(cntr_clr), .cntr_ld(cntr_ld),
    .cntr_ldval(cntr_ldval), .cntr(b_cntr),
    .flag_set(flag_set), .flag_clr(flag_clr), .flag_q(b_flag),
    .ff_d(ff_d), .ff_vld(ff_vld), .ff_q(b_ff)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers updated from the rules once per rising edge.
  bit m_valid = 1'b0;
  int ma_cntr, ma_flag, ma_ff;
  int mb_cntr, mb_flag, mb_ff;

  always @(posedge clk) begin
    if (!rst) begin
      m_valid = 1'b1;
      ma_cntr = 0;  ma_flag = 1; ma_ff = 0;
      mb_cntr = 3;  mb_flag = 0; mb_ff = 'h5A;
    end else begin
      if (cntr_clr)      ma_cntr = 0;
      else if (cntr_ld)  ma_cntr = cntr_ldval % 8;
      else if (cntr_adv) ma_cntr = (ma_cntr + 1) % 8;
      if (cntr_clr)      mb_cntr = 3;
      else if (cntr_adv) mb_cntr = (mb_cntr + 1) % 256;
      if (flag_set)      begin ma_flag = 1; mb_flag = 1; end
      else if (flag_clr) begin ma_flag = 0; mb_flag = 0; end
      if (ff_vld) ma_ff = ff_d;
      mb_ff = ff_d;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model a_cntr", 32'(a_cntr), 32'(ma_cntr));
      check("model a_flag", 32'(a_flag), 32'(ma_flag));
      check("model a_ff",   32'(a_ff),   32'(ma_ff));
      check("model b_cntr", 32'(b_cntr), 32'(mb_cntr));
      check("model b_flag", 32'(b_flag), 32'(mb_flag));
      check("model b_ff",   32'(b_ff),   32'(mb_ff));
    end
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cntr_adv = 0; cntr_clr = 0; cntr_ld = 0; cntr_ldval = 0;
    flag_set = 0; flag_clr = 0; ff_d = 0; ff_vld = 0;
  endtask

  initial begin
    int exp_wrap [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("reset a_cntr", 32'(a_cntr), 32'd0);
    check("reset a_flag", 32'(a_flag), 32'd1);
    check("reset a_ff",   32'(a_ff),   32'h00);
    check("reset b_cntr", 32'(b_cntr), 32'd3);
    check("reset b_flag", 32'(b_flag), 32'd0);
    check("reset b_ff",   32'(b_ff),   32'h5A);

    // Wrap of the 3-bit counter.
    rst = 1'b1;
    cntr_adv = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("wrap step %0d", i), 32'(a_cntr), 32'(exp_wrap[i]));
    end
    check("wrap b_cntr", 32'(b_cntr), 32'd12);

    // Clear beats advance.
    for (int i = 0; i < 4; i++) tick();
    check("pre-clr a_cntr", 32'(a_cntr), 32'd5);
    cntr_clr = 1;
    tick();
    check("clr+adv a_cntr", 32'(a_cntr), 32'd0);
    check("clr+adv b_cntr", 32'(b_cntr), 32'd3);
    cntr_clr = 0;

    // Load beats advance when enabled; ignored otherwise.
    tick();
    tick();
    check("pre-ld a_cntr", 32'(a_cntr), 32'd2);
    cntr_ld = 1; cntr_ldval = 8'd6;
    tick();
    check("ld+adv a_cntr", 32'(a_cntr), 32'd6);
    check("ld ignored b_cntr", 32'(b_cntr), 32'd6);
    cntr_ld = 0; cntr_adv = 0;

    // Flag: clear, set-wins, hold.
    flag_clr = 1;
    tick();
    check("flag clr a", 32'(a_flag), 32'd0);
    flag_set = 1;
    tick();
    check("flag both a", 32'(a_flag), 32'd1);
    check("flag both b", 32'(b_flag), 32'd1);
    flag_set = 0; flag_clr = 0;
    tick();
    check("flag hold 1", 32'(a_flag), 32'd1);
    flag_clr = 1;
    tick();
    flag_clr = 0;
    tick();
    check("flag hold 0", 32'(a_flag), 32'd0);
    check("cntr hold a", 32'(a_cntr), 32'd6);

    // Flip-flop, enabled (A) and free-running (B).
    ff_d = 8'hA5; ff_vld = 0;
    tick();
    check("ff vld0 a", 32'(a_ff), 32'h00);
    check("ff vld0 b", 32'(b_ff), 32'hA5);
    ff_vld = 1;
    tick();
    check("ff vld1 a", 32'(a_ff), 32'hA5);
    ff_d = 8'h3C; ff_vld = 0;
    tick();
    check("ff hold a", 32'(a_ff), 32'hA5);
    check("ff 3C b",   32'(b_ff), 32'h3C);
    ff_d = 8'h11; ff_vld = 1;
    tick();
    check("ff seq 11 b", 32'(b_ff), 32'h11);
    ff_d = 8'h22; ff_vld = 0;
    tick();
    check("ff seq 22 b", 32'(b_ff), 32'h22);
    check("ff seq hold a", 32'(a_ff), 32'h11);
    ff_d = 8'h33; ff_vld = 1;
    tick();
    check("ff seq 33 b", 32'(b_ff), 32'h33);

    // Mid-operation reset: reach cntr=4, flag=0, ff=0x55.
    cntr_clr = 1; flag_clr = 1; ff_d = 8'h55; ff_vld = 1;
    tick();
    cntr_clr = 0; flag_clr = 0; ff_vld = 0; cntr_adv = 1;
    for (int i = 0; i < 4; i++) tick();
    check("pre-rst a_cntr", 32'(a_cntr), 32'd4);
    check("pre-rst a_flag", 32'(a_flag), 32'd0);
    check("pre-rst a_ff",   32'(a_ff),   32'h55);
    check("pre-rst b_cntr", 32'(b_cntr), 32'd7);
    rst = 0;
    #2;
    check("rst pulse a_cntr", 32'(a_cntr), 32'd4);
    check("rst pulse a_flag", 32'(a_flag), 32'd0);
    check("rst pulse a_ff",   32'(a_ff),   32'h55);
    check("rst pulse b_ff",   32'(b_ff),   32'h55);
    rst = 1;
    #1;
    rst = 0; flag_set = 1; ff_d = 8'hFF; ff_vld = 1;
    tick();
    check("mid-rst a_cntr", 32'(a_cntr), 32'd0);
    check("mid-rst a_flag", 32'(a_flag), 32'd1);
    check("mid-rst a_ff",   32'(a_ff),   32'h00);
    check("mid-rst b_cntr", 32'(b_cntr), 32'd3);
    check("mid-rst b_flag", 32'(b_flag), 32'd0);
    check("mid-rst b_ff",   32'(b_ff),   32'h5A);
    rst = 1; flag_set = 0;
    tick();
    check("resume a_cntr", 32'(a_cntr), 32'd1);
    check("resume b_cntr", 32'(b_cntr), 32'd4);
    check("resume a_ff",   32'(a_ff),   32'hFF);

    // Randomized traffic; the negedge compare process checks against the model.
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 19) != 0);
      cntr_adv   = 1'($urandom_range(0, 3) != 0);
      cntr_clr   = 1'($urandom_range(0, 9) == 0);
      cntr_ld    = 1'($urandom_range(0, 5) == 0);
      cntr_ldval = 8'($urandom);
      flag_set   = 1'($urandom_range(0, 3) == 0);
      flag_clr   = 1'($urandom_range(0, 2) == 0);
      ff_d       = 8'($urandom);
      ff_vld     = 1'($urandom);
      tick();
    end

    idle_inputs();
    rst = 1;
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/powlib_cntr_flag_ff.md
POWLIB_CNTR_FLAG_FF -- requirements
Module: powlib_cntr_flag_ff

Interface
REQ-001 Parameter CNTR_W, default 8: counter width in bits.
REQ-002 Parameter CNTR_INIT, default 0: counter reset and clear value.
REQ-003 Parameter CNTR_ELD, default 0: 1 enables the counter load port; 0 ignores it.
REQ-004 Parameter FLAG_INIT, default 1: flag reset value.
REQ-005 Parameter FF_W, default 8: flip-flop data width.
REQ-006 Parameter FF_INIT, default 0: flip-flop reset value.
REQ-007 Parameter FF_EVLD, default 0: 1 makes the flip-flop load only when ff_vld is high.
REQ-008 clk  in  1  single clock; all state updates on the rising edge.
REQ-009 rst  in  1  reset, synchronous, active-low.
REQ-010 cntr_adv  in  1  increment request.
REQ-011 cntr_clr  in  1  clear request.
REQ-012 cntr_ld  in  1  load request.
REQ-013 cntr_ldval  in  CNTR_W  load value.
REQ-014 cntr  out  CNTR_W  registered count.
REQ-015 flag_set  in  1  set request.
REQ-016 flag_clr  in  1  clear request.
REQ-017 flag_q  out  1  registered flag.
REQ-018 ff_d  in  FF_W  data input.
REQ-019 ff_vld  in  1  load enable; used only when FF_EVLD=1.
REQ-020 ff_q  out  FF_W  registered data.

Function
REQ-021 All outputs come directly from registers, with no combinational path from inputs to outputs, and change one clock edge after their controlling inputs are sampled.
REQ-022 Counter next-state priority is: reset, then cntr_clr (loads CNTR_INIT), then cntr_ld when CNTR_ELD=1 (loads cntr_ldval), then cntr_adv (cntr+1), otherwise hold.
REQ-023 The counter increment wraps modulo 2^CNTR_W; all-ones+1 gives 0, with no saturation and no carry output.
REQ-024 When CNTR_ELD=0, cntr_ld and cntr_ldval have no effect.
REQ-025 When cntr_clr and cntr_adv are both high in the same cycle, the counter takes CNTR_INIT.
REQ-026 Flag next-state is: flag_set gives 1; otherwise flag_clr gives 0; otherwise hold.
REQ-027 When flag_set and flag_clr are both high in the same cycle, the flag is set to 1.
REQ-028 When FF_EVLD=0, ff_q takes ff_d on every edge.
REQ-029 When FF_EVLD=1, ff_q takes ff_d only on edges where ff_vld=1, and holds otherwise.
REQ-030 The three functions are independent; no input of one affects another.

Reset
REQ-031 On an edge with rst=0, cntr becomes CNTR_INIT, flag_q becomes FLAG_INIT and ff_q becomes FF_INIT, regardless of all other inputs.
REQ-032 Reset has no asynchronous effect; asserting rst between edges does not change any output.
REQ-033 Reset asserted mid-count or mid-load overrides that operation in the same cycle.
REQ-034 Operation resumes on the first edge with rst=1.
REQ-035 The outputs are defined from the first reset edge; no initial-value dependence is allowed.

Verification
REQ-036 Counter wrap, CNTR_W=3: reset, then cntr_adv=1 for 9 cycles -> cntr steps 1,2,...,7,0,1.
REQ-037 Counter priority: at cntr=5, drive clr=1 and adv=1 together -> cntr=0; with CNTR_ELD=1 and cntr=2, drive ld=1, ldval=6, adv=1 -> cntr=6; with CNTR_ELD=0, the same stimulus -> cntr=3.
REQ-038 Flag: after reset, flag_q=1; clr=1 -> 0; set=1 and clr=1 together -> 1; both inputs low -> flag holds.
REQ-039 Flip-flop, FF_EVLD=1, FF_W=8: d=0xA5 with vld=0 -> ff_q stays 0x00; vld=1 -> ff_q=0xA5; d=0x3C with vld=0 -> ff_q stays 0xA5.
REQ-040 Flip-flop, FF_EVLD=0: d sequence 0x11, 0x22, 0x33 -> ff_q shows the same sequence one cycle later, with ff_vld ignored.
REQ-041 Mid-operation reset: with cntr=4, flag_q=0 and ff_q=0x55, hold rst=0 for one edge while adv=1 and set=1 -> cntr=CNTR_INIT, flag_q=FLAG_INIT, ff_q=FF_INIT; a pulse of rst between edges causes no output change.
